turfio_gen_shift_arbiter: RTL and testbench
===========================================

# turfio_gen_shift_arbiter

Two-master Wishbone arbiter that shares the TURFIO general-purpose shift-register target (JTAG / LMK / SPI-flash / I2C-GPIO engine) between the TURF-side control master (M0) and the housekeeping/boot-sequencer master (M1). It grants the target to one master at a time and round-robins on contention. A per-master lock keeps ownership across multi-access transactions, such as an SPI command with CS_B held or an LMK word with LE sequencing. Access and lock timeouts stop a stuck master or target from hanging the bus.

## Interface
Parameters:
- ADR_W, 12: Wishbone byte-address width.
- ACK_TIMEOUT, 255: max cycles a target access may wait for ack before the arbiter errors it. Must be ≥1.
- LOCK_IDLE_MAX, 4095: max consecutive cycles a locked owner may hold the grant with cyc low. 0 disables the watchdog.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  M0 Wishbone strobes.
- m0_adr_i  in  ADR_W  M0 address.
- m0_dat_i  in  32  M0 write data.
- m0_sel_i  in  4  M0 byte selects.
- m0_lock_i  in  1  M0 requests ownership be held between cycles.
- m0_dat_o  out  32  read data to M0.
- m0_ack_o, m0_err_o, m0_rty_o  out  1 each  M0 terminations.
- m1_*  same set as m0_*, for M1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  target strobes.
- s_adr_o  out  ADR_W  target address.
- s_dat_o  out  32  target write data.
- s_sel_o  out  4  target byte selects.
- s_dat_i  in  32  target read data.
- s_ack_i, s_err_i, s_rty_i  in  1 each  target terminations.
- owner_o  out  2  one-hot current grant ({M1,M0}); 00 means idle.
- lock_expired_o  out  1  one-cycle pulse on watchdog release.
- timeout_o  out  1  one-cycle pulse on access timeout.

## Operation
- States: IDLE, OWN0, OWN1. State, owner_o and last_grant are registered.
- In IDLE, requests are m0_cyc_i and m1_cyc_i.
  - With one request, go to that master's OWN state.
  - With both, grant the master that is not last_grant.
  - Grant takes effect the cycle after the request is first seen in IDLE.
- In OWNn, target outputs mirror master n combinationally. s_cyc_o and s_stb_o are gated by the grant.
  - s_ack/err/rty route only to master n. The other master sees ack, err and rty all 0 and dat_o = 0, so it stalls.
  - m*_rty_o is driven only from s_rty_i. The arbiter never asserts rty itself.
- Release from OWNn to IDLE happens on the first cycle where mn_cyc_i=0 and the effective lock is 0. last_grant←n.
  - No back-to-back handoff: a pending request from the other master wins in the following IDLE cycle.
- Effective lock is mn_lock_i && !lock_block[n].
- Lock watchdog:
  - In OWNn with cyc=0 and lock=1, the idle counter increments. Any cyc=1 clears it.
  - When the counter reaches LOCK_IDLE_MAX (LOCK_IDLE_MAX≠0): force IDLE, pulse lock_expired_o, set lock_block[n].
  - lock_block[n] clears on the first cycle mn_lock_i=0.
- Access timeout:
  - The access counter increments while s_cyc_o && s_stb_o and no s_ack/err/rty. It clears on any termination or when stb drops.
  - At ACK_TIMEOUT: assert mn_err_o for exactly one cycle, force s_cyc_o/s_stb_o low that same cycle, pulse timeout_o. The grant is kept.
  - A target ack arriving in the timeout cycle is suppressed, so the master sees err only.
- Counter widths are $clog2(param+1). Counters saturate and do not wrap.
- Reset (any time, including mid-access):
  - state=IDLE, owner_o=00, last_grant=1 so M0 wins the first tie, counters=0, lock_block=00.
  - All s_* and m*_ outputs are 0.
  - An interrupted access is simply dropped. No ack or err is issued.

## Timing
- Arbitration latency is 1 cycle from cyc in IDLE to s_cyc_o.
- Data path adds zero latency once granted: s_ack_i→mn_ack_o is combinational, same cycle.
- Minimum gap between owners is 1 IDLE cycle.
- timeout_o, lock_expired_o and the forced err are registered-decision pulses, exactly one wb_clk_i cycle wide.

## Structure
- Package turfio_gen_shift_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t
  - localparams M0=0, M1=1
- Sub-module wb_arb_watchdog: a saturating counter with clear, enable and `hit` at a programmable limit, where limit 0 means never hit. Instantiate it twice, for access timeout and lock idle.

## Test plan
- Single master: M0 writes 0xDEADBEEF to adr 0x004, target acks after 3 cycles → s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o on the ack cycle; owner_o=01 then 00.
- Contention after reset: M0 and M1 raise cyc in the same cycle → M0 granted first; after M0 drops cyc, one IDLE cycle, then M1 granted (owner_o 01→00→10). Repeat with both requesting again → M0 again, since last_grant=M1.
- Lock hold: M1 asserts lock, does 3 accesses with cyc gaps of 5 cycles while M0 requests → M0 is never granted until M1 drops lock with cyc low.
- Lock watchdog: LOCK_IDLE_MAX=16, M0 locked with cyc=0 → after 16 cycles lock_expired_o pulses and M1 is granted. M0 holding lock high does not regain lock priority until it pulses lock low.
- Access timeout: ACK_TIMEOUT=8, target never acks → m0_err_o and timeout_o are high for exactly one cycle, 8 cycles after stb; s_stb_o is low that cycle; M1 sees no err.
- Reset mid-access: assert wb_rst_i during an M1 access → all outputs 0 asynchronously; after release, M0 wins a simultaneous request.

Source files
------------

// File: rtl/turfio_gen_shift_arb_pkg.sv
// Shared types and master indices for the TURFIO shift-register target arbiter.
package turfio_gen_shift_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int M0 = 0;
    localparam int M1 = 1;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Saturating event counter with synchronous clear; hit flags when the count
// reaches LIMIT. LIMIT of 0 disables the hit output entirely.
module wb_arb_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt;

    // Count enabled cycles, clear on request, hold once the limit is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT_C)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (LIMIT != 0) && (cnt == LIMIT_C);

endmodule

// File: rtl/turfio_gen_shift_arbiter.sv
// Two-master Wishbone arbiter for the TURFIO shift-register target.
//
//   state | meaning
//   IDLE  | no owner; arbitrate pending cyc requests (round-robin on ties)
//   OWN0  | M0 owns the target; target bus mirrors M0
//   OWN1  | M1 owns the target; target bus mirrors M1
module turfio_gen_shift_arbiter
    import turfio_gen_shift_arb_pkg::*;
#(
    parameter int ADR_W         = 12,
    parameter int ACK_TIMEOUT   = 255,
    parameter int LOCK_IDLE_MAX = 4095
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [31:0]      m0_dat_i,
    input  logic [3:0]       m0_sel_i,
    input  logic             m0_lock_i,
    output logic [31:0]      m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    output logic             m0_rty_o,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [31:0]      m1_dat_i,
    input  logic [3:0]       m1_sel_i,
    input  logic             m1_lock_i,
    output logic [31:0]      m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic             m1_rty_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [31:0]      s_dat_o,
    output logic [3:0]       s_sel_o,
    input  logic [31:0]      s_dat_i,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    input  logic             s_rty_i,
    output logic [1:0]       owner_o,
    output logic             lock_expired_o,
    output logic             timeout_o
);

    arb_state_t state, state_next;
    logic       last_grant;
    logic [1:0] lock_block;

    logic own0, own1, owned;
    logic cur_cyc, cur_stb, cur_lock;
    logic raw_access, term;
    logic acc_hit, lock_hit;

    assign own0  = (state == OWN0);
    assign own1  = (state == OWN1);
    assign owned = own0 | own1;

    // Lock honoured only while the watchdog has not blocked that master.
    assign cur_cyc  = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
    assign cur_stb  = (own0 & m0_stb_i) | (own1 & m1_stb_i);
    assign cur_lock = (own0 & m0_lock_i & ~lock_block[M0]) |
                      (own1 & m1_lock_i & ~lock_block[M1]);

    assign raw_access = cur_cyc & cur_stb;
    assign term       = s_ack_i | s_err_i | s_rty_i;

    wb_arb_watchdog #(.LIMIT(ACK_TIMEOUT)) u_acc_wd (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .clr (~raw_access | term | acc_hit),
        .en  (raw_access),
        .hit (acc_hit)
    );

    wb_arb_watchdog #(.LIMIT(LOCK_IDLE_MAX)) u_lock_wd (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .clr (~owned | cur_cyc | lock_hit),
        .en  (owned & ~cur_cyc & cur_lock),
        .hit (lock_hit)
    );

    // State, registered grant indication, round-robin pointer and lock blocks.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            owner_o    <= 2'b00;
            last_grant <= 1'b1;
            lock_block <= 2'b00;
        end else begin
            state   <= state_next;
            owner_o <= {state_next == OWN1, state_next == OWN0};
            if (owned && (state_next == IDLE)) begin
                last_grant <= own1;
            end
            if (!m0_lock_i) begin
                lock_block[M0] <= 1'b0;
            end else if (lock_hit && own0) begin
                lock_block[M0] <= 1'b1;
            end
            if (!m1_lock_i) begin
                lock_block[M1] <= 1'b0;
            end else if (lock_hit && own1) begin
                lock_block[M1] <= 1'b1;
            end
        end
    end

    // Next-state decision and the combinational target/master muxing.
    always_comb begin
        state_next     = state;
        s_cyc_o        = 1'b0;
        s_stb_o        = 1'b0;
        s_we_o         = 1'b0;
        s_adr_o        = '0;
        s_dat_o        = '0;
        s_sel_o        = '0;
        m0_dat_o       = '0;
        m0_ack_o       = 1'b0;
        m0_err_o       = 1'b0;
        m0_rty_o       = 1'b0;
        m1_dat_o       = '0;
        m1_ack_o       = 1'b0;
        m1_err_o       = 1'b0;
        m1_rty_o       = 1'b0;
        timeout_o      = acc_hit & owned;
        lock_expired_o = lock_hit & owned;

        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_next = (last_grant == 1'(M0)) ? OWN1 : OWN0;
                end else if (m0_cyc_i) begin
                    state_next = OWN0;
                end else if (m1_cyc_i) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                s_cyc_o  = m0_cyc_i & ~acc_hit;
                s_stb_o  = m0_stb_i & ~acc_hit;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i & ~acc_hit;
                m0_err_o = s_err_i | acc_hit;
                m0_rty_o = s_rty_i & ~acc_hit;
                if (lock_hit || (!m0_cyc_i && !cur_lock)) begin
                    state_next = IDLE;
                end
            end
            OWN1: begin
                s_cyc_o  = m1_cyc_i & ~acc_hit;
                s_stb_o  = m1_stb_i & ~acc_hit;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i & ~acc_hit;
                m1_err_o = s_err_i | acc_hit;
                m1_rty_o = s_rty_i & ~acc_hit;
                if (lock_hit || (!m1_cyc_i && !cur_lock)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_turfio_gen_shift_arbiter.sv
// Directed bench for turfio_gen_shift_arbiter (ACK_TIMEOUT=8, LOCK_IDLE_MAX=16).
module tb_turfio_gen_shift_arbiter;

    localparam int ADR_W = 12;

    logic             wb_clk_i;
    logic             wb_rst_i;
    logic             m0_cyc_i, m0_stb_i, m0_we_i, m0_lock_i;
    logic [ADR_W-1:0] m0_adr_i;
    logic [31:0]      m0_dat_i;
    logic [3:0]       m0_sel_i;
    logic [31:0]      m0_dat_o;
    logic             m0_ack_o, m0_err_o, m0_rty_o;
    logic             m1_cyc_i, m1_stb_i, m1_we_i, m1_lock_i;
    logic [ADR_W-1:0] m1_adr_i;
    logic [31:0]      m1_dat_i;
    logic [3:0]       m1_sel_i;
    logic [31:0]      m1_dat_o;
    logic             m1_ack_o, m1_err_o, m1_rty_o;
    logic             s_cyc_o, s_stb_o, s_we_o;
    logic [ADR_W-1:0] s_adr_o;
    logic [31:0]      s_dat_o;
    logic [3:0]       s_sel_o;
    logic [31:0]      s_dat_i;
    logic             s_ack_i, s_err_i, s_rty_i;
    logic [1:0]       owner_o;
    logic             lock_expired_o, timeout_o;

    int checks = 0;
    int errors = 0;

    turfio_gen_shift_arbiter #(
        .ADR_W         (ADR_W),
        .ACK_TIMEOUT   (8),
        .LOCK_IDLE_MAX (16)
    ) dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .m0_cyc_i       (m0_cyc_i),
        .m0_stb_i       (m0_stb_i),
        .m0_we_i        (m0_we_i),
        .m0_adr_i       (m0_adr_i),
        .m0_dat_i       (m0_dat_i),
        .m0_sel_i       (m0_sel_i),
        .m0_lock_i      (m0_lock_i),
        .m0_dat_o       (m0_dat_o),
        .m0_ack_o       (m0_ack_o),
        .m0_err_o       (m0_err_o),
        .m0_rty_o       (m0_rty_o),
        .m1_cyc_i       (m1_cyc_i),
        .m1_stb_i       (m1_stb_i),
        .m1_we_i        (m1_we_i),
        .m1_adr_i       (m1_adr_i),
        .m1_dat_i       (m1_dat_i),
        .m1_sel_i       (m1_sel_i),
        .m1_lock_i      (m1_lock_i),
        .m1_dat_o       (m1_dat_o),
        .m1_ack_o       (m1_ack_o),
        .m1_err_o       (m1_err_o),
        .m1_rty_o       (m1_rty_o),
        .s_cyc_o        (s_cyc_o),
        .s_stb_o        (s_stb_o),
        .s_we_o         (s_we_o),
        .s_adr_o        (s_adr_o),
        .s_dat_o        (s_dat_o),
        .s_sel_o        (s_sel_o),
        .s_dat_i        (s_dat_i),
        .s_ack_i        (s_ack_i),
        .s_err_i        (s_err_i),
        .s_rty_i        (s_rty_i),
        .owner_o        (owner_o),
        .lock_expired_o (lock_expired_o),
        .timeout_o      (timeout_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are changed here.
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Let combinational outputs settle after an input change before sampling.
    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_lock_i = 0;
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_lock_i = 0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
        s_dat_i = '0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        wb_rst_i = 1'b1;
        tick();
        tick();
        wb_rst_i = 1'b0;
    endtask

    initial begin
        wb_rst_i = 1'b1;
        clear_inputs();
        tick();
        settle();
        check_val("rst_owner", 32'(owner_o), 32'h0);
        check_val("rst_s_cyc", 32'(s_cyc_o), 32'h0);
        check_val("rst_pulses", 32'({lock_expired_o, timeout_o}), 32'h0);
        wb_rst_i = 1'b0;

        // ---- single master write ----
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1;
        m0_adr_i = 12'h004; m0_dat_i = 32'hDEADBEEF; m0_sel_i = 4'hF;
        settle();
        check_val("s1_req_cycle_s_cyc", 32'(s_cyc_o), 32'h0);
        tick();
        settle();
        check_val("s1_grant_s_cyc", 32'(s_cyc_o), 32'h1);
        check_val("s1_owner", 32'(owner_o), 32'h1);
        check_val("s1_adr", 32'(s_adr_o), 32'h004);
        check_val("s1_dat", s_dat_o, 32'hDEADBEEF);
        check_val("s1_we_sel", 32'({s_we_o, s_sel_o}), 32'h1F);
        tick();
        tick();
        settle();
        check_val("s1_no_ack_yet", 32'(m0_ack_o), 32'h0);
        tick();
        s_ack_i = 1;
        settle();
        check_val("s1_ack", 32'(m0_ack_o), 32'h1);
        check_val("s1_m1_ack", 32'(m1_ack_o), 32'h0);
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        settle();
        check_val("s1_owner_hold", 32'(owner_o), 32'h1);
        tick();
        settle();
        check_val("s1_owner_release", 32'(owner_o), 32'h0);
        check_val("s1_s_cyc_low", 32'(s_cyc_o), 32'h0);

        // ---- contention after reset ----
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 12'h010;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 12'h020;
        tick();
        s_ack_i = 1; s_dat_i = 32'h1234_5678;
        settle();
        check_val("c_first_owner", 32'(owner_o), 32'h1);
        check_val("c_first_adr", 32'(s_adr_o), 32'h010);
        check_val("c_m0_ack", 32'(m0_ack_o), 32'h1);
        check_val("c_m0_dat", m0_dat_o, 32'h1234_5678);
        check_val("c_m1_stall", 32'({m1_ack_o, m1_err_o, m1_rty_o}), 32'h0);
        check_val("c_m1_dat", m1_dat_o, 32'h0);
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        settle();
        check_val("c_gap_owner", 32'(owner_o), 32'h0);
        check_val("c_gap_s_cyc", 32'(s_cyc_o), 32'h0);
        tick();
        s_rty_i = 1;
        settle();
        check_val("c_second_owner", 32'(owner_o), 32'h2);
        check_val("c_second_adr", 32'(s_adr_o), 32'h020);
        check_val("c_m1_rty", 32'(m1_rty_o), 32'h1);
        check_val("c_m0_rty", 32'(m0_rty_o), 32'h0);
        tick();
        s_rty_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1;
        m1_cyc_i = 1; m1_stb_i = 1;
        settle();
        check_val("c_gap2_owner", 32'(owner_o), 32'h0);
        tick();
        settle();
        check_val("c_rr_owner", 32'(owner_o), 32'h1);

        // ---- lock hold ----
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1; m1_lock_i = 1;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1;
        for (int a = 0; a < 3; a++) begin
            m1_cyc_i = 1; m1_stb_i = 1; s_ack_i = 1;
            settle();
            check_val("l_m1_ack", 32'(m1_ack_o), 32'h1);
            check_val("l_owner_access", 32'(owner_o), 32'h2);
            tick();
            s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
            for (int g = 0; g < 5; g++) begin
                settle();
                check_val("l_owner_gap", 32'(owner_o), 32'h2);
                check_val("l_m0_stall", 32'(m0_ack_o), 32'h0);
                tick();
            end
        end
        m1_lock_i = 0;
        settle();
        check_val("l_owner_unlock", 32'(owner_o), 32'h2);
        tick();
        settle();
        check_val("l_owner_idle", 32'(owner_o), 32'h0);
        tick();
        settle();
        check_val("l_owner_m0", 32'(owner_o), 32'h1);

        // ---- lock watchdog ----
        do_reset();
        m0_cyc_i = 1; m0_lock_i = 1;
        tick();
        m0_cyc_i = 0; m1_cyc_i = 1;
        for (int k = 0; k < 16; k++) begin
            settle();
            check_val("w_hold_owner", 32'(owner_o), 32'h1);
            check_val("w_no_expire", 32'(lock_expired_o), 32'h0);
            tick();
        end
        settle();
        check_val("w_expire", 32'(lock_expired_o), 32'h1);
        tick();
        settle();
        check_val("w_expire_pulse", 32'(lock_expired_o), 32'h0);
        check_val("w_idle", 32'(owner_o), 32'h0);
        tick();
        m1_cyc_i = 0;
        settle();
        check_val("w_m1_owner", 32'(owner_o), 32'h2);
        tick();
        m0_cyc_i = 1;
        tick();
        m0_cyc_i = 0;
        settle();
        check_val("w_m0_regrant", 32'(owner_o), 32'h1);
        tick();
        settle();
        check_val("w_blocked_release", 32'(owner_o), 32'h0);
        m0_lock_i = 0;
        tick();
        m0_lock_i = 1; m0_cyc_i = 1;
        tick();
        m0_cyc_i = 0;
        tick();
        settle();
        check_val("w_lock_restored", 32'(owner_o), 32'h1);
        m0_lock_i = 0;
        tick();
        tick();

        // ---- access timeout ----
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        settle();
        check_val("t_s_stb_start", 32'(s_stb_o), 32'h1);
        for (int k = 1; k < 8; k++) begin
            tick();
            settle();
            check_val("t_no_err", 32'({m0_err_o, timeout_o}), 32'h0);
            check_val("t_s_stb_wait", 32'(s_stb_o), 32'h1);
        end
        tick();
        s_ack_i = 1;
        settle();
        check_val("t_err", 32'(m0_err_o), 32'h1);
        check_val("t_timeout", 32'(timeout_o), 32'h1);
        check_val("t_ack_suppressed", 32'(m0_ack_o), 32'h0);
        check_val("t_s_cyc_stb_low", 32'({s_cyc_o, s_stb_o}), 32'h0);
        check_val("t_m1_no_err", 32'(m1_err_o), 32'h0);
        tick();
        s_ack_i = 0;
        settle();
        check_val("t_err_pulse", 32'({m0_err_o, timeout_o}), 32'h0);
        check_val("t_grant_kept", 32'(owner_o), 32'h1);
        check_val("t_s_stb_back", 32'(s_stb_o), 32'h1);

        // ---- reset mid-access ----
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        s_ack_i = 1;
        settle();
        check_val("r_m1_active", 32'({owner_o, s_cyc_o, m1_ack_o}), 32'hB);
        wb_rst_i = 1;
        #1;
        check_val("r_async_owner", 32'(owner_o), 32'h0);
        check_val("r_async_s", 32'({s_cyc_o, s_stb_o}), 32'h0);
        check_val("r_async_m1", 32'({m1_ack_o, m1_err_o}), 32'h0);
        tick();
        s_ack_i = 0; m0_cyc_i = 1; m0_stb_i = 1;
        wb_rst_i = 0;
        tick();
        settle();
        check_val("r_m0_wins", 32'(owner_o), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
